// File: rtl/jtkiwi_obj_linebuf.sv
// Double-buffered sprite line buffer with erase-after-read readout and a
// sprite-over-tilemap priority mixer that produces the palette index.
module jtkiwi_obj_linebuf #(
    parameter int         AW       = 9,
    parameter logic [8:0] BACKDROP = 9'h000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [AW-1:0] hdump,
    input  logic          obj_we,
    input  logic [AW-1:0] obj_xpos,
    input  logic [8:0]    obj_pxl,
    input  logic [8:0]    scr_pxl,
    output logic          busy,
    output logic [8:0]    col_addr
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]    r_state;
    logic [AW:0]   r_cnt;
    logic          r_rd_bank;
    logic          r_lhbl_l;
    logic          r_lvbl_l;
    logic [8:0]    r_obj_l;
    logic [8:0]    r_scr_l;
    logic          r_erase;
    logic [AW-1:0] r_erase_addr;

    logic          w_clear;
    logic          w_lhbl_fall;
    logic          w_lvbl_fall;
    logic          w_rd_en;
    logic          w_spr_we;
    logic [1:0][8:0] w_rd;

    function automatic logic [8:0] f_mix(input logic [8:0] obj, input logic [8:0] scr);
        if (obj[3:0] != 4'd0)
            return obj;
        else if (scr[3:0] != 4'd0)
            return scr;
        else
            return BACKDROP;
    endfunction

    assign w_clear     = (r_state == ST_CLEAR);
    assign w_lhbl_fall = pxl_cen & r_lhbl_l & ~LHBL;
    assign w_lvbl_fall = pxl_cen & r_lvbl_l & ~LVBL;
    assign w_rd_en     = pxl_cen & ~w_clear & LHBL & LVBL;
    assign w_spr_we    = obj_we & (obj_pxl[3:0] != 4'd0);
    assign busy        = w_clear;

    // Each bank sees at most one writer per clk: the sweep, the erase (read
    // bank, one clk after the read) or the sprite engine (the other bank).
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BK = 1'(b);

        logic [8:0]    r_mem [0:2**AW-1];
        logic          w_we;
        logic [AW-1:0] w_waddr;
        logic [8:0]    w_wdata;

        always_comb begin
            w_we    = 1'b0;
            w_waddr = '0;
            w_wdata = '0;
            if (w_clear) begin
                w_we    = (r_cnt[AW] == BK);
                w_waddr = r_cnt[AW-1:0];
            end else if (r_erase && r_rd_bank == BK) begin
                w_we    = 1'b1;
                w_waddr = r_erase_addr;
            end else if (w_spr_we && r_rd_bank != BK) begin
                w_we    = 1'b1;
                w_waddr = obj_xpos;
                w_wdata = obj_pxl;
            end
        end

        always_ff @(posedge clk) begin
            if (w_we)
                r_mem[w_waddr] <= w_wdata;
        end

        assign w_rd[b] = r_mem[hdump];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_rd_bank    <= 1'b0;
            r_lhbl_l     <= 1'b0;
            r_lvbl_l     <= 1'b0;
            r_obj_l      <= '0;
            r_scr_l      <= '0;
            r_erase      <= 1'b0;
            r_erase_addr <= '0;
            col_addr     <= '0;
        end else begin
            r_erase <= w_rd_en;
            if (w_rd_en)
                r_erase_addr <= hdump;

            if (pxl_cen) begin
                r_lhbl_l <= LHBL;
                r_lvbl_l <= LVBL;
                r_scr_l  <= scr_pxl;
                r_obj_l  <= w_rd_en ? w_rd[r_rd_bank] : 9'd0;
                col_addr <= w_clear ? BACKDROP : f_mix(r_obj_l, r_scr_l);
                if (w_lhbl_fall)
                    r_rd_bank <= ~r_rd_bank;
            end

            // Vertical blank start restarts the sweep from either state
            if (w_lvbl_fall) begin
                r_state <= ST_CLEAR;
                r_cnt   <= '0;
            end else if (w_clear) begin
                if (r_cnt == '1)
                    r_state <= ST_RUN;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtkiwi_obj_linebuf.sv
// Bench for jtkiwi_obj_linebuf: directed line scenarios plus random lines,
// every clk compared against a behavioural line-buffer model.
module tb_jtkiwi_obj_linebuf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pxl_cen;
    logic       LHBL;
    logic       LVBL;
    logic [8:0] hdump;
    logic       obj_we;
    logic [8:0] obj_xpos;
    logic [8:0] obj_pxl;
    logic [8:0] scr_pxl;
    logic       busy0, busy1;
    logic [8:0] col0, col1;

    int n_vec = 0;
    int n_err = 0;
    bit rnd_wr = 0;

    jtkiwi_obj_linebuf u_dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .hdump(hdump), .obj_we(obj_we), .obj_xpos(obj_xpos), .obj_pxl(obj_pxl),
        .scr_pxl(scr_pxl), .busy(busy0), .col_addr(col0)
    );

    jtkiwi_obj_linebuf #(.BACKDROP(9'h1F0)) u_dut_bd (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .hdump(hdump), .obj_we(obj_we), .obj_xpos(obj_xpos), .obj_pxl(obj_pxl),
        .scr_pxl(scr_pxl), .busy(busy1), .col_addr(col1)
    );

    always #5 clk = ~clk;

    // Behavioural model: two line arrays, a sweep countdown and the mixer rule
    logic [8:0] m_bank [2][512];
    bit         m_clear;
    int         m_cnt;
    int         m_rd;
    bit         m_lh, m_lv;
    logic [8:0] m_obj, m_scr, m_col0, m_col1;

    function automatic logic [8:0] mix(input logic [8:0] o, input logic [8:0] s,
                                       input logic [8:0] bd);
        if (o[3:0] != 0) return o;
        if (s[3:0] != 0) return s;
        return bd;
    endfunction

    task automatic model_reset();
        m_clear = 1; m_cnt = 0; m_rd = 0; m_lh = 0; m_lv = 0;
        m_obj = 0; m_scr = 0; m_col0 = 0; m_col1 = 0;
        foreach (m_bank[i, j]) m_bank[i][j] = 0;
    endtask

    task automatic model_step();
        bit lhf, lvf;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lhf = pxl_cen && m_lh && !LHBL;
        lvf = pxl_cen && m_lv && !LVBL;
        if (m_clear)
            m_bank[m_cnt / 512][m_cnt % 512] = 0;
        else if (obj_we && obj_pxl[3:0] != 0)
            m_bank[1 - m_rd][obj_xpos] = obj_pxl;
        if (pxl_cen) begin
            m_col0 = m_clear ? 9'h000 : mix(m_obj, m_scr, 9'h000);
            m_col1 = m_clear ? 9'h1F0 : mix(m_obj, m_scr, 9'h1F0);
            if (!m_clear && LHBL && LVBL) begin
                m_obj = m_bank[m_rd][hdump];
                m_bank[m_rd][hdump] = 0;
            end else begin
                m_obj = 0;
            end
            m_scr = scr_pxl;
            m_lh  = LHBL;
            m_lv  = LVBL;
            if (lhf) m_rd = 1 - m_rd;
        end
        if (m_clear) begin
            if (lvf)               m_cnt = 0;
            else if (m_cnt == 1023) m_clear = 0;
            else                   m_cnt++;
        end else if (lvf) begin
            m_clear = 1;
            m_cnt   = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        if (rnd_wr) begin
            obj_we   = 1'($urandom);
            obj_xpos = 9'($urandom);
            obj_pxl  = 9'($urandom);
            if (($urandom & 3) == 0) obj_pxl[3:0] = 4'd0;
        end
        model_step();
        @(posedge clk);
        #1;
        chk("busy", {8'd0, busy0}, {8'd0, m_clear});
        chk("busy_bd", {8'd0, busy1}, {8'd0, m_clear});
        chk("col", col0, m_col0);
        chk("col_bd", col1, m_col1);
    endtask

    task automatic pix(input logic [8:0] h, input logic lh, input int gap);
        pxl_cen = 1; hdump = h; LHBL = lh;
        tick();
        pxl_cen = 0;
        repeat (gap) tick();
    endtask

    task automatic wr(input logic [8:0] x, input logic [8:0] p);
        obj_we = 1; obj_xpos = x; obj_pxl = p;
        tick();
        obj_we = 0;
    endtask

    // rnd: random scr pixels and cen spacing; otherwise fixed scr and gap 1
    task automatic scan(input int start, input int n, input logic [8:0] scr, input bit rnd);
        for (int h = start; h < start + n; h++) begin
            scr_pxl = scr;
            if (rnd) begin
                scr_pxl = 9'($urandom);
                if (($urandom & 3) == 0) scr_pxl[3:0] = 4'd0;
            end
            pix(9'(h), 1'b1, rnd ? $urandom_range(1, 3) : 1);
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) pix(9'(i), 1'b0, 1);
    endtask

    initial begin
        rst_n = 0; pxl_cen = 0; LHBL = 0; LVBL = 1; hdump = 0;
        obj_we = 0; obj_xpos = 0; obj_pxl = 0; scr_pxl = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_col", col0, 9'h000);
        chk("rst_busy", {8'd0, busy0}, 9'd1);
        rst_n = 1;
        repeat (1030) tick();
        chk("clear_done", {8'd0, busy0}, 9'd0);

        // Both banks empty after the sweep
        scan(0, 512, 9'h000, 0); blank(4);
        scan(0, 512, 9'h000, 0); blank(4);

        // Line with one opaque and one transparent sprite pixel
        wr(10, 9'h0A5); wr(11, 9'h0B0);
        scan(0, 8, 9'h013, 0); blank(4);
        scan(0, 11, 9'h013, 0); pix(11, 1'b1, 1);
        chk("x10_obj", col0, 9'h0A5);
        pix(12, 1'b1, 1);
        chk("x11_transp", col0, 9'h013);
        scan(13, 243, 9'h013, 0); blank(4);

        // Same bank again after two swaps: erased
        scan(0, 256, 9'h013, 0); blank(4);
        scan(0, 11, 9'h013, 0); pix(11, 1'b1, 1);
        chk("x10_erased", col0, 9'h013);
        scan(12, 244, 9'h013, 0); blank(4);

        // Last write wins
        wr(5, 9'h021); wr(5, 9'h031);
        scan(0, 8, 9'h013, 0); blank(4);
        scan(0, 6, 9'h013, 0); pix(6, 1'b1, 1);
        chk("x5_last", col0, 9'h031);
        scan(7, 9, 9'h013, 0); blank(4);

        // Both layers transparent
        scan(0, 4, 9'h020, 0); pix(4, 1'b1, 1);
        chk("backdrop", col0, 9'h000);
        chk("backdrop_1f0", col1, 9'h1F0);
        blank(4);

        // Vertical blank with pending entries in both banks
        wr(20, 9'h0C7); wr(30, 9'h0D9);
        scan(0, 4, 9'h000, 0); blank(2);
        wr(40, 9'h0E1);
        LVBL = 0; blank(2); LVBL = 1;
        chk("vbl_busy", {8'd0, busy0}, 9'd1);
        rnd_wr = 1;
        repeat (300) tick();
        LVBL = 0; blank(1); LVBL = 1;  // restart the sweep mid-way
        repeat (400) tick();
        rnd_wr = 0; rst_n = 0; tick(); rst_n = 1; rnd_wr = 1;
        repeat (1100) tick();
        rnd_wr = 0;
        chk("vbl_done", {8'd0, busy0}, 9'd0);
        scan(0, 512, 9'h000, 0); blank(4);
        scan(0, 512, 9'h000, 0); blank(4);

        // Random lines with concurrent sprite writes
        for (int l = 0; l < 12; l++) begin
            rnd_wr = 1;
            scan(0, 256, 9'h000, 1);
            blank(8);
            if (l == 6) begin
                LVBL = 0; blank(2); LVBL = 1;
                repeat (1030) tick();
            end
        end
        rnd_wr = 0; obj_we = 0;
        scan(0, 256, 9'h000, 1); blank(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtkiwi_obj_linebuf.md
Name: jtkiwi_obj_linebuf

Overview:
- Double-buffered sprite line buffer plus layer priority mixer; sits directly upstream of the palette/colour mixer.
- The sprite engine draws line N+1 into one bank while line N is read out of the other bank.
- Readout is erase-after-read. Each sprite pixel is merged with the delayed tilemap pixel.
- The result is the 9-bit palette index col_addr, consumed by the colour mixer on the same pxl_cen.

Parameters:
- AW, 9: buffer address width; each bank has 2^AW entries × 9 bits.
- BACKDROP, 9'h000: palette index output when both layers are transparent.

Ports:
- clk, in, 1: video clock; all logic is clocked on posedge.
- rst_n, in, 1: asynchronous active-low reset.
- pxl_cen, in, 1: pixel clock enable. It never asserts on two consecutive clk cycles.
- LHBL, in, 1: horizontal blank, active low.
- LVBL, in, 1: vertical blank, active low.
- hdump, in, AW: current read-out column, valid on pxl_cen.
- obj_we, in, 1: sprite engine pixel write strobe, single clk.
- obj_xpos, in, AW: write column.
- obj_pxl, in, 9: {palette bank[4:0], colour[3:0]}; colour 0 means transparent.
- scr_pxl, in, 9: tilemap pixel, same format, valid on pxl_cen.
- busy, out, 1: high while the clear sweep runs.
- col_addr, out, 9: mixed palette index to the colour mixer.

Behaviour:
Reset
- While rst_n is low: col_addr=0, busy=1, rd_bank=0, state=CLEAR, clear counter=0, all pipeline registers=0.

State machine
- CLEAR
  - Each clk, write 0 to address cnt[AW-1:0] of bank cnt[AW].
  - Count 0 to 2^(AW+1)-1 (1024 clk at AW=9).
  - obj_we is ignored. col_addr is held at BACKDROP on every pxl_cen. busy=1.
  - After the last address, go to RUN with busy=0.
- RUN
  - Normal operation as described below.
- Returning to CLEAR
  - A falling edge of LVBL (sampled on pxl_cen) moves RUN to CLEAR with cnt=0.
  - A falling LVBL edge seen while already in CLEAR restarts the count.

Bank swap
- On pxl_cen, when LHBL was 1 last pxl_cen and is 0 now, rd_bank toggles. The write bank is always ~rd_bank.
- The swap happens in both states. In CLEAR it only matters for which bank is read next.

Write path (RUN only)
- If obj_we=1 and obj_pxl[3:0]!=0, write obj_pxl to write bank[obj_xpos].
- Transparent writes are dropped.
- On repeated writes to the same address, the last write wins.
- A write in the same clk as a swap targets the write bank as defined before the toggle.

Read path (RUN, pxl_cen, LHBL=1 and LVBL=1)
- Read rd_bank[hdump] into obj_l.
- On the next clk, write 0 to rd_bank[hdump] (erase).
- Because pxl_cen never asserts on consecutive clocks, the erase never collides with the next read. It also never collides with the sprite write, which uses the other bank.
- During blanking, no read and no erase take place, and obj_l is forced to 0.
- hdump beyond 2^AW wraps modulo 2^AW.

Mixer
- On each pxl_cen, scr_l <= scr_pxl, so the tile layer is delayed one pixel to align with the RAM read.
- col_addr, registered on pxl_cen:
  - obj_l[3:0]!=0 → obj_l
  - else scr_l[3:0]!=0 → scr_l
  - else BACKDROP
- Latency: col_addr reflects the hdump/scr_pxl presented one pxl_cen earlier.
- col_addr is updated during blanking too; it shows scr_l/BACKDROP because obj_l=0.

Reset mid-operation
- An rst_n assertion at any time aborts immediately to the reset values, followed by a full CLEAR.

Test Plan:
1. Reset release, idle inputs
   - busy stays 1 for exactly 1024 clk, then 0.
   - Every bank address reads 0.
   - col_addr=BACKDROP=9'h000.
2. Write line N: obj_pxl=9'h0A5 at xpos 10, and 9'h0B0 (transparent) at xpos 11. Then swap via an LHBL fall and scan hdump 0..255 with scr_pxl=9'h013.
   - The pxl_cen after hdump=10 gives col_addr=9'h0A5.
   - All other columns give 9'h013.
3. Repeat the scan of the same bank after another two swaps, with no new writes.
   - xpos 10 now gives 9'h013, because the entry was erased after read.
4. Write 9'h021 then 9'h031 to xpos 5 in the same line.
   - Readout gives col_addr=9'h031 (last write wins).
5. scr_pxl=9'h020 (transparent) with an empty obj entry.
   - col_addr=BACKDROP.
   - Rerun with BACKDROP=9'h1F0: col_addr=9'h1F0.
6. Assert an LVBL fall with entries pending.
   - busy=1 for 1024 clk.
   - Afterwards both banks are 0.
   - obj_we during the sweep leaves no trace.
   - Pulsing rst_n low mid-sweep restarts the count at 0.
